stage_branch_register: RTL and testbench
========================================

// Module: stage_branch_register
// PURPOSE
//  Stage (ST) and branch (BR1/BR2) register feeding sq_register and the crosspoint logic.
//  Holds the 2-bit instruction stage and the two branch flags tested by multi-stage instructions.
//  Stage requests are latched during a memory cycle time (MCT) and take effect at the end-of-MCT strobe (T12).
//  Branch flags are loaded from the write bus by single-cycle test commands.
// PARAMETERS
//  WORD_W       16  write-bus width; bit WORD_W is sign/overflow (S2), bit WORD_W-1 is S1/L15
//  RESET_STAGE  0   stage value (0..3) loaded by reset and by GOJAM
// PORTS
//  CLOCK      in   1       system clock; all state changes on rising edge
//  SIM_RST_n  in   1       asynchronous, active-low reset
//  GOJAM      in   1       synchronous hardware restart; same effect as reset, active high
//  T12_n      in   1       end-of-MCT strobe, active low, one CLOCK wide
//  ST1        in   1       request: set stage bit 1 at next T12
//  ST2        in   1       request: set stage bit 2 at next T12
//  TSGN       in   1       test sign: BR1 <= sign bit
//  TSGN2      in   1       test sign into BR2: BR2 <= sign bit
//  TOV        in   1       test overflow: BR1 <= sign bit, BR2 <= sign XOR bit WORD_W-1
//  TMZ        in   1       test minus zero: BR2 <= (bus == all ones)
//  TPZG       in   1       test plus zero / greater: BR2 <= (bus == 0)
//  WL_n       in   WORD_W  write bus, active low (bit i high = logic 0)
//  ST0_n      out  1       stage==0, active low
//  ST1_n      out  1       stage==1, active low
//  ST2_n      out  1       stage==2, active low
//  ST3_n      out  1       stage==3, active low
//  STD2       out  1       stage==2 (decoded, active high)
//  BR1, BR1_n out  1       branch flag 1 and complement
//  BR2, BR2_n out  1       branch flag 2 and complement
//  BR1B2B     out  1       BR1 & ~BR2
//  BR12B      out  1       ~BR1 & ~BR2
// BEHAVIOUR
//  - Reset (SIM_RST_n=0, async): stage=RESET_STAGE, pending={0,0}, BR1=BR2=0; outputs follow
//    (default: ST0_n=0, ST1_n=ST2_n=ST3_n=1, STD2=0, BR1=0, BR1_n=1, BR2=0, BR2_n=1, BR1B2B=0, BR12B=1).
//  - GOJAM=1 on an edge: identical state to reset; overrides every other input that cycle.
//  - Pending register: on each edge, pend1 |= ST1, pend2 |= ST2 (sticky within the MCT).
//  - T12_n=0 on an edge: stage <= {pend2|ST2, pend1|ST1} (requests in the T12 cycle itself count);
//    pending cleared to 0. No request in the MCT -> stage returns to 0.
//  - Stage outputs are registered decodes of stage; exactly one STx_n low at all times.
//    Change visible one edge after the T12 cycle (latency 1 clock).
//  - Bus decode: bus = ~WL_n; sign = bus[WORD_W-1]; s1 = bus[WORD_W-2]; zero = (bus==0);
//    mzero = (bus=={WORD_W{1}}). Sampled combinationally in the cycle the test is asserted.
//  - BR1 update: TSGN or TOV -> BR1 <= sign; else hold.
//  - BR2 update priority (highest first): TOV -> sign^s1; TSGN2 -> sign; TMZ -> mzero; TPZG -> zero; else hold.
//  - Tests and T12 in same cycle: both take effect independently (branch and stage are separate).
//  - All outputs change only on CLOCK edges or async reset; no combinational path input->output.
//  - Reset deasserted mid-MCT: pending starts empty; a T12 with no prior request gives stage 0.
// TESTING
//  1. Reset: assert SIM_RST_n=0 mid-cycle -> ST0_n=0 immediately, BR1=BR2=0, BR12B=1, STD2=0.
//  2. ST2 pulse at cycle 3, T12_n low at cycle 11 -> ST2_n=0, STD2=1 after cycle 11 edge; next
//     T12 with no request -> ST0_n=0, STD2=0.
//  3. ST1 at cycle 2 and ST2 at cycle 6 in same MCT -> ST3_n=0 after T12; ST1 in the T12 cycle
//     alone -> ST1_n=0.
//  4. TOV with WL_n=16'h7FFF (bus 8000) -> BR1=1, BR2=1; with WL_n=16'hBFFF (bus 4000) -> BR1=0,
//     BR2=1, BR1B2B=0; with WL_n=16'hFFFF -> BR1=0, BR2=0, BR12B=1.
//  5. TMZ with WL_n=16'h0000 -> BR2=1; TPZG with WL_n=16'hFFFF -> BR2=1; TMZ+TPZG together with
//     WL_n=16'hFFFF -> BR2=0 (TMZ wins); TSGN+TMZ with bus 8000 -> BR1=1, BR2=0.
//  6. GOJAM with pending ST1, BR1=1, and T12_n=0 same cycle -> stage 0, BR1=BR2=0, pending
//     cleared (following T12 gives ST0_n=0).

Source files
------------

// File: rtl/stage_branch_register_if.sv
// Control, write-bus and decoded-output bundle for the stage/branch register.
// The master side drives commands and the write bus; the slave side returns the decodes.
interface stage_branch_register_if #(
  parameter int unsigned WordW = 16
);
  logic             gojam;
  logic             t12_n;
  logic             st1;
  logic             st2;
  logic             tsgn;
  logic             tsgn2;
  logic             tov;
  logic             tmz;
  logic             tpzg;
  logic [WordW-1:0] wl_n;

  logic st0_n;
  logic st1_n;
  logic st2_n;
  logic st3_n;
  logic std2;
  logic br1;
  logic br1_n;
  logic br2;
  logic br2_n;
  logic br1b2b;
  logic br12b;

  modport master (
    output gojam, t12_n, st1, st2, tsgn, tsgn2, tov, tmz, tpzg, wl_n,
    input  st0_n, st1_n, st2_n, st3_n, std2, br1, br1_n, br2, br2_n, br1b2b, br12b
  );

  modport slave (
    input  gojam, t12_n, st1, st2, tsgn, tsgn2, tov, tmz, tpzg, wl_n,
    output st0_n, st1_n, st2_n, st3_n, std2, br1, br1_n, br2, br2_n, br1b2b, br12b
  );
endinterface

// File: rtl/stage_branch_register.sv
// Instruction stage (ST) and branch flags (BR1/BR2). Stage requests accumulate over an MCT
// and commit at the T12 strobe; branch flags load from the active-low write bus on test commands.
module stage_branch_register #(
  parameter int unsigned WordW      = 16,
  parameter int unsigned ResetStage = 0
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  stage_branch_register_if.slave bus_io
);
  localparam logic [1:0] RstStage = ResetStage[1:0];

  logic [1:0]       stage_q, stage_d;
  logic [1:0]       pend_q, pend_d;
  logic             br1_q, br1_d;
  logic             br2_q, br2_d;
  logic [WordW-1:0] bus;
  logic             sign, s1, zero, mzero;

  always_comb begin
    bus   = ~bus_io.wl_n;
    sign  = bus[WordW-1];
    s1    = bus[WordW-2];
    zero  = (bus == '0);
    mzero = (bus == '1);
  end

  always_comb begin
    stage_d = stage_q;
    br1_d   = br1_q;
    br2_d   = br2_q;
    // Requests raised in the T12 cycle itself still count toward the committed stage.
    pend_d  = pend_q | {bus_io.st2, bus_io.st1};

    if (!bus_io.t12_n) begin
      stage_d = pend_d;
      pend_d  = 2'b00;
    end

    if (bus_io.tsgn || bus_io.tov) begin
      br1_d = sign;
    end

    if (bus_io.tov) begin
      br2_d = sign ^ s1;
    end else if (bus_io.tsgn2) begin
      br2_d = sign;
    end else if (bus_io.tmz) begin
      br2_d = mzero;
    end else if (bus_io.tpzg) begin
      br2_d = zero;
    end

    if (bus_io.gojam) begin
      stage_d = RstStage;
      pend_d  = 2'b00;
      br1_d   = 1'b0;
      br2_d   = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stage_q <= RstStage;
      pend_q  <= 2'b00;
      br1_q   <= 1'b0;
      br2_q   <= 1'b0;
    end else begin
      stage_q <= stage_d;
      pend_q  <= pend_d;
      br1_q   <= br1_d;
      br2_q   <= br2_d;
    end
  end

  // Outputs decode registered state only, so no input reaches an output combinationally.
  always_comb begin
    bus_io.st0_n  = (stage_q != 2'd0);
    bus_io.st1_n  = (stage_q != 2'd1);
    bus_io.st2_n  = (stage_q != 2'd2);
    bus_io.st3_n  = (stage_q != 2'd3);
    bus_io.std2   = (stage_q == 2'd2);
    bus_io.br1    = br1_q;
    bus_io.br1_n  = ~br1_q;
    bus_io.br2    = br2_q;
    bus_io.br2_n  = ~br2_q;
    bus_io.br1b2b = br1_q & ~br2_q;
    bus_io.br12b  = ~br1_q & ~br2_q;
  end
endmodule

// File: tb/tb_stage_branch_register.sv
// Directed bench for stage_branch_register: the driver queues hand-computed expectations,
// a monitor pops one per clock and compares the decoded outputs.
module tb_stage_branch_register;
  localparam logic [8:0] CGj    = 9'h100;
  localparam logic [8:0] CT12   = 9'h080;
  localparam logic [8:0] CSt1   = 9'h040;
  localparam logic [8:0] CSt2   = 9'h020;
  localparam logic [8:0] CTsgn  = 9'h010;
  localparam logic [8:0] CTsgn2 = 9'h008;
  localparam logic [8:0] CTov   = 9'h004;
  localparam logic [8:0] CTmz   = 9'h002;
  localparam logic [8:0] CTpzg  = 9'h001;

  typedef struct {
    logic [10:0] vec;
    string       name;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;
  exp_t sb[$];

  stage_branch_register_if #(.WordW(16)) bus ();

  stage_branch_register #(
    .WordW     (16),
    .ResetStage(0)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus_io(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output order: st0_n st1_n st2_n st3_n std2 br1 br1_n br2 br2_n br1b2b br12b
  function automatic logic [10:0] ev(input logic [1:0] s, input logic b1, input logic b2);
    return {s != 2'd0, s != 2'd1, s != 2'd2, s != 2'd3, s == 2'd2,
            b1, ~b1, b2, ~b2, b1 & ~b2, ~b1 & ~b2};
  endfunction

  function automatic logic [10:0] actual();
    return {bus.st0_n, bus.st1_n, bus.st2_n, bus.st3_n, bus.std2,
            bus.br1, bus.br1_n, bus.br2, bus.br2_n, bus.br1b2b, bus.br12b};
  endfunction

  task automatic step(input logic [8:0] c, input logic [15:0] wl, input logic [1:0] es,
                      input logic eb1, input logic eb2, input string nm);
    exp_t e;
    @(negedge clk);
    bus.gojam = c[8];
    bus.t12_n = ~c[7];
    bus.st1   = c[6];
    bus.st2   = c[5];
    bus.tsgn  = c[4];
    bus.tsgn2 = c[3];
    bus.tov   = c[2];
    bus.tmz   = c[1];
    bus.tpzg  = c[0];
    bus.wl_n  = wl;
    e.vec  = ev(es, eb1, eb2);
    e.name = nm;
    sb.push_back(e);
  endtask

  task automatic idle(input int n, input logic [1:0] es, input logic eb1, input logic eb2,
                      input string nm);
    for (int i = 0; i < n; i++) step(9'h000, 16'hFFFF, es, eb1, eb2, nm);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        checks++;
        if (actual() !== e.vec) begin
          failures++;
          $display("FAIL %s: outputs=%b expected=%b", e.name, actual(), e.vec);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n     = 1'b1;
    bus.gojam = 1'b0;
    bus.t12_n = 1'b1;
    bus.st1   = 1'b0;
    bus.st2   = 1'b0;
    bus.tsgn  = 1'b0;
    bus.tsgn2 = 1'b0;
    bus.tov   = 1'b0;
    bus.tmz   = 1'b0;
    bus.tpzg  = 1'b0;
    bus.wl_n  = 16'hFFFF;

    // Asynchronous reset asserted between clock edges.
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if (actual() !== ev(2'd0, 1'b0, 1'b0)) begin
      failures++;
      $display("FAIL async_reset: outputs=%b expected=%b", actual(), ev(2'd0, 1'b0, 1'b0));
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Single ST2 request committed at T12, then an empty MCT returns to stage 0.
    idle(3, 2'd0, 1'b0, 1'b0, "t2_pre");
    step(CSt2, 16'hFFFF, 2'd0, 1'b0, 1'b0, "t2_req_pending");
    idle(7, 2'd0, 1'b0, 1'b0, "t2_wait");
    step(CT12, 16'hFFFF, 2'd2, 1'b0, 1'b0, "t2_t12_stage2");
    idle(11, 2'd2, 1'b0, 1'b0, "t2_hold2");
    step(CT12, 16'hFFFF, 2'd0, 1'b0, 1'b0, "t2_empty_mct");

    // Two requests in one MCT accumulate; a request in the T12 cycle alone counts.
    idle(2, 2'd0, 1'b0, 1'b0, "t3_pre");
    step(CSt1, 16'hFFFF, 2'd0, 1'b0, 1'b0, "t3_st1");
    idle(3, 2'd0, 1'b0, 1'b0, "t3_mid");
    step(CSt2, 16'hFFFF, 2'd0, 1'b0, 1'b0, "t3_st2");
    idle(4, 2'd0, 1'b0, 1'b0, "t3_wait");
    step(CT12, 16'hFFFF, 2'd3, 1'b0, 1'b0, "t3_t12_stage3");
    idle(11, 2'd3, 1'b0, 1'b0, "t3_hold3");
    step(CT12 | CSt1, 16'hFFFF, 2'd1, 1'b0, 1'b0, "t3_t12_same_cycle_req");

    // TOV decode of sign and sign^s1.
    step(CTov, 16'h7FFF, 2'd1, 1'b1, 1'b1, "tov_8000");
    step(CTov, 16'hBFFF, 2'd1, 1'b0, 1'b1, "tov_4000");
    step(CTov, 16'hFFFF, 2'd1, 1'b0, 1'b0, "tov_0000");
    step(CTsgn, 16'h7FFF, 2'd1, 1'b1, 1'b0, "tsgn_br1b2b");
    idle(2, 2'd1, 1'b1, 1'b0, "br_hold");

    // BR2 zero tests and priority chain.
    step(CTmz, 16'h0000, 2'd1, 1'b1, 1'b1, "tmz_ffff");
    step(CTmz, 16'hFFFF, 2'd1, 1'b1, 1'b0, "tmz_0000");
    step(CTpzg, 16'hFFFF, 2'd1, 1'b1, 1'b1, "tpzg_zero");
    step(CTmz | CTpzg, 16'hFFFF, 2'd1, 1'b1, 1'b0, "tmz_over_tpzg");
    step(CTpzg, 16'hFFFF, 2'd1, 1'b1, 1'b1, "tpzg_set");
    step(CTsgn | CTmz, 16'h7FFF, 2'd1, 1'b1, 1'b0, "tsgn_tmz");
    step(CTpzg, 16'hFFFF, 2'd1, 1'b1, 1'b1, "tpzg_set2");
    step(CTsgn2 | CTpzg, 16'hFFFF, 2'd1, 1'b1, 1'b0, "tsgn2_over_tpzg");
    step(CTpzg, 16'hFFFF, 2'd1, 1'b1, 1'b1, "tpzg_set3");
    step(CTov | CTsgn2, 16'h3FFF, 2'd1, 1'b1, 1'b0, "tov_over_tsgn2");
    step(CTsgn2, 16'h7FFF, 2'd1, 1'b1, 1'b1, "tsgn2_8000");

    // T12 and a branch test in the same cycle act independently.
    step(CT12 | CSt2 | CTsgn, 16'hFFFF, 2'd2, 1'b0, 1'b1, "t12_with_tsgn");

    // GOJAM overrides pending request, T12 and tests in the same cycle.
    step(CTsgn, 16'h7FFF, 2'd2, 1'b1, 1'b1, "gj_prep_br1");
    step(CSt1, 16'hFFFF, 2'd2, 1'b1, 1'b1, "gj_prep_pend");
    step(CGj | CT12 | CSt1 | CTsgn | CTsgn2, 16'h7FFF, 2'd0, 1'b0, 1'b0, "gojam");
    idle(2, 2'd0, 1'b0, 1'b0, "gj_after");
    step(CT12, 16'hFFFF, 2'd0, 1'b0, 1'b0, "gj_pend_cleared");

    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: left=%0d expected=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
